// File: rtl/servo_angle_sequencer_pkg.sv
// Shared definitions for the servo angle sequencer: state encoding, angle indices
// and the default MG995 compare codes (50 MHz clock).
package servo_angle_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_e;

    localparam logic [1:0] IDX_0      = 2'd0;
    localparam logic [1:0] IDX_90     = 2'd1;
    localparam logic [1:0] IDX_180    = 2'd2;
    localparam logic [1:0] IDX_IGNORE = 2'd3;

    localparam int ANGLE_0_C   = 24999;
    localparam int ANGLE_90_C  = 74999;
    localparam int ANGLE_180_C = 124999;

endpackage

// File: rtl/servo_angle_sequencer_frame_timer.sv
// PWM frame counter: counts 0..FRAME_CYCLES_P-1 while enabled, flags the wrap edge
// combinationally and registers a one-cycle tick for the cycle in which the count is 0.
module servo_angle_sequencer_frame_timer #(
    parameter int FRAME_CYCLES_P = 1000000,
    parameter int FRAME_W_P      = 20
) (
    input  logic Clk_i,
    input  logic Reset_i,
    input  logic Enable_i,
    output logic Frame_tick_o,
    output logic Wrap_o
);

    localparam logic [FRAME_W_P-1:0] FRAME_LAST = FRAME_W_P'(FRAME_CYCLES_P - 1);

    logic [FRAME_W_P-1:0] frame_cnt_q;
    logic                 frame_tick_q;

    assign Wrap_o       = Enable_i && (frame_cnt_q == FRAME_LAST);
    assign Frame_tick_o = frame_tick_q;

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            frame_cnt_q  <= '0;
            frame_tick_q <= 1'b0;
        end else if (!Enable_i) begin
            frame_cnt_q  <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_cnt_q  <= Wrap_o ? '0 : frame_cnt_q + 1'b1;
            frame_tick_q <= Wrap_o;
        end
    end

endmodule

// File: rtl/servo_angle_sequencer.sv
// Chooses the MG995 angle (manual select or 0/90/180 ping-pong sweep) and applies it
// only at a PWM frame boundary while the UART reporter is idle, then dwells before the next change.
module servo_angle_sequencer
    import servo_angle_sequencer_pkg::*;
#(
    parameter int DATA_W_P       = 17,
    parameter int ANGLE_0_P      = ANGLE_0_C,
    parameter int ANGLE_90_P     = ANGLE_90_C,
    parameter int ANGLE_180_P    = ANGLE_180_C,
    parameter int FRAME_CYCLES_P = 1000000,
    parameter int FRAME_W_P      = 20,
    parameter int DWELL_FRAMES_P = 50,
    parameter int DWELL_W_P      = 8
) (
    input  logic                Clk_i,
    input  logic                Reset_i,
    input  logic                Enable_i,
    input  logic                Mode_i,
    input  logic [1:0]          Angle_sel_i,
    input  logic                Uart_busy_i,
    output logic [DATA_W_P-1:0] Data_o,
    output logic [1:0]          Angle_idx_o,
    output logic                Frame_tick_o,
    output logic                Uart_en_o,
    output logic                Busy_o
);

    localparam logic [DWELL_W_P-1:0] DWELL_LAST = DWELL_W_P'(DWELL_FRAMES_P - 1);

    seq_state_e            state_q, state_d;
    logic [1:0]            target_q, target_d;
    logic [1:0]            idx_q, idx_d;
    logic [DWELL_W_P-1:0]  dwell_q, dwell_d;
    logic                  dir_up_q, dir_up_d;
    logic [DATA_W_P-1:0]   data_q, data_d;
    logic                  frame_tick;
    logic                  wrap;

    function automatic logic [DATA_W_P-1:0] angle_code(input logic [1:0] idx);
        case (idx)
            IDX_90:  angle_code = DATA_W_P'(ANGLE_90_P);
            IDX_180: angle_code = DATA_W_P'(ANGLE_180_P);
            default: angle_code = DATA_W_P'(ANGLE_0_P);
        endcase
    endfunction

    servo_angle_sequencer_frame_timer #(
        .FRAME_CYCLES_P (FRAME_CYCLES_P),
        .FRAME_W_P      (FRAME_W_P)
    ) u_frame_timer (
        .Clk_i        (Clk_i),
        .Reset_i      (Reset_i),
        .Enable_i     (Enable_i),
        .Frame_tick_o (frame_tick),
        .Wrap_o       (wrap)
    );

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state_q  <= ST_IDLE;
            target_q <= IDX_0;
            idx_q    <= IDX_0;
            dwell_q  <= '0;
            dir_up_q <= 1'b1;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            idx_q    <= idx_d;
            dwell_q  <= dwell_d;
            dir_up_q <= dir_up_d;
            data_q   <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        idx_d    = idx_q;
        dwell_d  = dwell_q;
        dir_up_d = dir_up_q;
        data_d   = data_q;

        // Disabling wins over everything but keeps the angle index and sweep direction.
        if (!Enable_i) begin
            state_d = ST_IDLE;
            data_d  = '0;
            dwell_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_PENDING;
                    target_d = (!Mode_i && Angle_sel_i != IDX_IGNORE) ? Angle_sel_i : idx_q;
                end
                ST_PENDING: begin
                    if (wrap && !Uart_busy_i) begin
                        data_d  = angle_code(target_q);
                        idx_d   = target_q;
                        dwell_d = '0;
                        state_d = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (frame_tick) begin
                        if (dwell_q == DWELL_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (Mode_i) begin
                        state_d = ST_PENDING;
                        // Ping-pong; a manual move may leave the direction pointing off the end.
                        if (dir_up_q && idx_q != IDX_180) begin
                            target_d = idx_q + 2'd1;
                            dir_up_d = (idx_q != IDX_90);
                        end else if (!dir_up_q && idx_q != IDX_0) begin
                            target_d = idx_q - 2'd1;
                            dir_up_d = (idx_q == IDX_90);
                        end else begin
                            target_d = IDX_90;
                            dir_up_d = (idx_q == IDX_0);
                        end
                    end else if (Angle_sel_i != IDX_IGNORE && Angle_sel_i != idx_q) begin
                        target_d = Angle_sel_i;
                        state_d  = ST_PENDING;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign Data_o       = data_q;
    assign Angle_idx_o  = idx_q;
    assign Frame_tick_o = frame_tick;
    assign Uart_en_o    = (state_q != ST_IDLE);
    assign Busy_o       = (state_q == ST_PENDING) || (state_q == ST_SETTLE);

endmodule
